// File: rtl/usr_serializer_ctrl_pkg.sv
// Shared definitions for the 4-bit serializer: datapath width, shift-register
// mode encodings and the controller state enumeration.
package usr_serializer_ctrl_pkg;

  localparam int WIDTH = 4;
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    MODE_HOLD = 2'd0,
    MODE_SHL  = 2'd1,
    MODE_SHR  = 2'd2,
    MODE_LOAD = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/usr_serializer_ctrl_core.sv
// Universal 4-bit shift register: hold, shift left, shift right or parallel
// load, with zero fill on shifts.
module usr4_core
  import usr_serializer_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  // NOTE: q_d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    q_d = q_q;
    case (mode_i)
      MODE_SHL:  q_d = {q_q[WIDTH-2:0], 1'b0};
      MODE_SHR:  q_d = {1'b0, q_q[WIDTH-1:1]};
      MODE_LOAD: q_d = d_i;
      default:   q_d = q_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/usr_serializer_ctrl.sv
// Serializer controller: accepts a 4-bit word, streams it MSB- or LSB-first
// under sink backpressure, then pulses done for one cycle.
module usr_serializer_ctrl
  import usr_serializer_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dir,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             done,
  output logic             busy,
  output logic [WIDTH-1:0] reg_q,
  output logic [1:0]       reg_mode
);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             dir_q;
  mode_e            mode;

  // NOTE: async reset clears control state; the shift register has its own reset in the core.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            state_q <= ST_SHIFT;
            cnt_q   <= '0;
            dir_q   <= in_dir;
          end
        end
        ST_SHIFT: begin
          if (ser_ready) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Mode is Mealy on purpose: the shift must happen in the same cycle the sink consumes.
  always_comb begin
    mode = MODE_HOLD;
    case (state_q)
      ST_IDLE:  if (in_valid && rst) mode = MODE_LOAD;
      ST_SHIFT: if (ser_ready) mode = dir_q ? MODE_SHR : MODE_SHL;
      default:  mode = MODE_HOLD;
    endcase
  end

  usr4_core u_core (
    .clk    (clk),
    .rst_n  (rst),
    .mode_i (mode),
    .d_i    (in_data),
    .q_o    (reg_q)
  );

  assign busy      = (state_q != ST_IDLE);
  assign in_ready  = (state_q == ST_IDLE) && rst;
  assign ser_valid = (state_q == ST_SHIFT);
  assign ser_out   = ser_valid && (dir_q ? reg_q[0] : reg_q[WIDTH-1]);
  assign done      = (state_q == ST_DONE);
  assign reg_mode  = mode;

endmodule

// File: tb/tb_usr_serializer_ctrl.sv
// Directed bench for usr_serializer_ctrl: reset behaviour, both bit orders,
// backpressure, mid-word reset and back-to-back words.
module tb_usr_serializer_ctrl;
  import usr_serializer_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       in_dir;
  logic       ser_out;
  logic       ser_valid;
  logic       ser_ready;
  logic       done;
  logic       busy;
  logic [3:0] reg_q;
  logic [1:0] reg_mode;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  usr_serializer_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dir    (in_dir),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .ser_ready (ser_ready),
    .done      (done),
    .busy      (busy),
    .reg_q     (reg_q),
    .reg_mode  (reg_mode)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge; inputs change and outputs are read here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Serialize one word from IDLE. exp_bits lists emitted bits first-at-[3];
  // rdy_pat[c] is ser_ready in the c-th SHIFT cycle; exp_lat is accept-to-done cycles.
  task automatic run_word(input string tag, input logic [3:0] data, input logic dir,
                          input logic [3:0] exp_bits, input logic [15:0] rdy_pat,
                          input int exp_lat);
    int k;
    int c;
    check({tag, "_idle_ready"}, in_ready, 1);
    in_valid = 1'b1;
    in_data  = data;
    in_dir   = dir;
    #1;
    check({tag, "_mode_load"}, reg_mode, MODE_LOAD);
    step();
    in_valid = 1'b0;
    in_data  = ~data;
    in_dir   = ~dir;
    k = 0;
    c = 0;
    while (k < 4 && c < 40) begin
      ser_ready = (c < 16) ? rdy_pat[c] : 1'b1;
      #1;
      check({tag, "_ser_valid"}, ser_valid, 1);
      check({tag, "_in_ready_lo"}, in_ready, 0);
      check({tag, "_bit"}, ser_out, exp_bits[3-k]);
      if (ser_ready) begin
        check({tag, "_mode_shift"}, reg_mode, dir ? MODE_SHR : MODE_SHL);
        k++;
      end else begin
        check({tag, "_mode_hold"}, reg_mode, MODE_HOLD);
      end
      step();
      c++;
    end
    check({tag, "_bits_consumed"}, k, 4);
    ser_ready = 1'b0;
    #1;
    check({tag, "_latency"}, c + 1, exp_lat);
    check({tag, "_done"}, done, 1);
    check({tag, "_done_ser_valid"}, ser_valid, 0);
    check({tag, "_done_in_ready"}, in_ready, 0);
    check({tag, "_done_mode"}, reg_mode, MODE_HOLD);
    check({tag, "_zero_fill"}, reg_q, 4'b0000);
    step();
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_back_idle"}, busy, 0);
    check({tag, "_ready_again"}, in_ready, 1);
  endtask

  // Back-to-back words with in_valid held high: per-cycle expectations.
  logic [11:0] b2b_ready = 12'b100000100000;  // cycle 0 at bit 11
  logic [11:0] b2b_done  = 12'b000001000001;
  logic [11:0] b2b_bits  = 12'b010110001100;  // 1011 then 0110 on cycles 1-4, 7-10

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b1;
    in_data   = 4'b1111;
    in_dir    = 1'b0;
    ser_ready = 1'b0;

    // Reset with a word offered: nothing loads, all outputs quiet.
    step();
    step();
    check("rst_in_ready", in_ready, 0);
    check("rst_ser_valid", ser_valid, 0);
    check("rst_ser_out", ser_out, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_mode", reg_mode, MODE_HOLD);
    check("rst_reg_q", reg_q, 4'b0000);
    in_valid = 1'b0;
    rst      = 1'b1;
    step();
    check("post_rst_reg_q", reg_q, 4'b0000);
    check("post_rst_ready", in_ready, 1);

    run_word("msb", 4'b1011, 1'b0, 4'b1011, 16'hFFFF, 5);
    run_word("lsb", 4'b1011, 1'b1, 4'b1101, 16'hFFFF, 5);
    run_word("bp",  4'b0110, 1'b0, 4'b0110, 16'hFFD9, 8);

    // Reset after two bits of 1100 abandons the word.
    in_valid = 1'b1;
    in_data  = 4'b1100;
    in_dir   = 1'b0;
    step();
    in_valid  = 1'b0;
    ser_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    check("mid_rst_reg_q", reg_q, 4'b0000);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_in_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("mid_rst_no_done", done, 0);
    end
    ser_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_release_ready", in_ready, 1);
    check("mid_rst_release_busy", busy, 0);
    step();
    run_word("after_rst", 4'b0001, 1'b0, 4'b0001, 16'hFFFF, 5);

    // Two words with in_valid held high throughout.
    in_valid  = 1'b1;
    in_data   = 4'b1011;
    in_dir    = 1'b0;
    ser_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      check("b2b_in_ready", in_ready, b2b_ready[11-c]);
      check("b2b_done", done, b2b_done[11-c]);
      if ((c >= 1 && c <= 4) || (c >= 7 && c <= 10))
        check("b2b_bit", ser_out, b2b_bits[11-c]);
      step();
      if (c == 0) in_data = 4'b0110;
    end
    in_valid  = 1'b0;
    ser_ready = 1'b0;
    #1;
    check("b2b_end_ready", in_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
